// File: rtl/spi_sfr_seq_if.sv
// rtl/spi_sfr_seq_if.sv - stream and SFR bus bundle between spi_sfr_seq and its surroundings
// Purpose: groups the tx/rx byte streams, slave-select, SFR write/read ports and status flags.
// Modports:
//   master : the sequencer view (drives tx_ready, rx_*, spssn, SFR write port, sfraddr_r, busy, err_timeout)
//   slave  : the environment view (drives tx_*, ss_sel, rx_ready, sfr_data)
interface spi_sfr_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] ss_sel;
  logic [7:0] spssn;
  logic [1:0] sfraddr_w;
  logic       sfrwe;
  logic [7:0] spidata;
  logic [2:0] sfraddr_r;
  logic [7:0] sfr_data;
  logic       busy;
  logic       err_timeout;

  modport master (
    input  tx_data, tx_valid, rx_ready, ss_sel, sfr_data,
    output tx_ready, rx_data, rx_valid, spssn, sfraddr_w, sfrwe, spidata, sfraddr_r,
           busy, err_timeout
  );

  modport slave (
    output tx_data, tx_valid, rx_ready, ss_sel, sfr_data,
    input  tx_ready, rx_data, rx_valid, spssn, sfraddr_w, sfrwe, spidata, sfraddr_r,
           busy, err_timeout
  );
endinterface

// File: rtl/spi_sfr_seq.sv
// rtl/spi_sfr_seq.sv - SFR-bus sequencer turning a byte stream into spi_ms master transfers
// Purpose: configures the SPI core after reset, writes each accepted tx byte to the core's
//   transmit register, polls the status register for a fresh done flag, reads the received
//   byte back and returns it on the rx stream. One byte in flight at a time.
// Ports:
//   clk          : system clock shared with the SPI core
//   rst_n        : asynchronous active-low reset
//   bus (master) : tx stream (tx_data/tx_valid/tx_ready + ss_sel), rx stream
//                  (rx_data/rx_valid/rx_ready), spssn, SFR write port (sfraddr_w/sfrwe/spidata),
//                  SFR read port (sfraddr_r/sfr_data), busy, err_timeout
module spi_sfr_seq #(
  parameter logic [7:0] CR1_VAL = 8'h10,
  parameter logic [7:0] CR2_VAL = 8'h00,
  parameter logic [7:0] BR_VAL  = 8'h03,
  parameter int         TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_sfr_seq_if.master bus
);

  localparam int            TW          = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM        = TW'(TIMEOUT);
  localparam logic [1:0]    ADDR_CR1    = 2'd0;
  localparam logic [1:0]    ADDR_CR2    = 2'd1;
  localparam logic [1:0]    ADDR_BR     = 2'd2;
  localparam logic [1:0]    ADDR_TXDATA = 2'd3;
  localparam logic [2:0]    ADDR_STATUS = 3'd3;
  localparam logic [2:0]    ADDR_RXDATA = 3'd5;
  // status register stage plus read-data register stage in the core
  localparam logic [1:0]    SETTLE      = 2'd2;

  typedef enum logic [3:0] {
    CFG1,
    CFG2,
    CFGBR,
    IDLE,
    LOAD,
    WAIT_LO,
    WAIT_HI,
    RD,
    OUT
  } state_t;

  state_t        state, state_n;
  logic          tx_ready_q, tx_ready_n;
  logic [7:0]    rx_data_q, rx_data_n;
  logic          rx_valid_q, rx_valid_n;
  logic [7:0]    spssn_q, spssn_n;
  logic [1:0]    sfraddr_w_q, sfraddr_w_n;
  logic          sfrwe_q, sfrwe_n;
  logic [7:0]    spidata_q, spidata_n;
  logic [2:0]    sfraddr_r_q, sfraddr_r_n;
  logic          busy_q, busy_n;
  logic          err_q, err_n;
  logic [1:0]    settle_q, settle_n;
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic [TW-1:0] tcnt_inc;
  logic          timeout_hit;
  logic          accept;

  assign accept      = bus.tx_valid && tx_ready_q;
  // one counter spans both wait states; it saturates rather than wrapping
  assign tcnt_inc    = (tcnt_q == TLIM) ? tcnt_q : tcnt_q + TW'(1);
  assign timeout_hit = (tcnt_inc == TLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CFG1;
      tx_ready_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      spssn_q     <= 8'hFF;
      sfraddr_w_q <= 2'd0;
      sfrwe_q     <= 1'b0;
      spidata_q   <= 8'h00;
      sfraddr_r_q <= 3'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      settle_q    <= 2'd0;
      tcnt_q      <= '0;
    end else begin
      state       <= state_n;
      tx_ready_q  <= tx_ready_n;
      rx_data_q   <= rx_data_n;
      rx_valid_q  <= rx_valid_n;
      spssn_q     <= spssn_n;
      sfraddr_w_q <= sfraddr_w_n;
      sfrwe_q     <= sfrwe_n;
      spidata_q   <= spidata_n;
      sfraddr_r_q <= sfraddr_r_n;
      busy_q      <= busy_n;
      err_q       <= err_n;
      settle_q    <= settle_n;
      tcnt_q      <= tcnt_n;
    end
  end

  // Every output is registered, so this block computes the value each output
  // register takes at the next edge, together with the next state.
  always_comb begin
    state_n     = state;
    tx_ready_n  = 1'b0;
    rx_data_n   = rx_data_q;
    rx_valid_n  = rx_valid_q;
    spssn_n     = spssn_q;
    sfraddr_w_n = sfraddr_w_q;
    sfrwe_n     = 1'b0;
    spidata_n   = spidata_q;
    sfraddr_r_n = sfraddr_r_q;
    err_n       = 1'b0;
    settle_n    = settle_q;
    tcnt_n      = tcnt_q;

    unique case (state)
      CFG1: begin
        sfrwe_n     = 1'b1;
        sfraddr_w_n = ADDR_CR1;
        spidata_n   = CR1_VAL;
        state_n     = CFG2;
      end
      CFG2: begin
        sfrwe_n     = 1'b1;
        sfraddr_w_n = ADDR_CR2;
        spidata_n   = CR2_VAL;
        state_n     = CFGBR;
      end
      CFGBR: begin
        sfrwe_n     = 1'b1;
        sfraddr_w_n = ADDR_BR;
        spidata_n   = BR_VAL;
        state_n     = IDLE;
      end
      IDLE: begin
        if (accept) begin
          // the tx byte goes straight into the write-data register, which
          // the LOAD cycle presents to the core together with sfrwe
          spssn_n     = bus.ss_sel;
          sfrwe_n     = 1'b1;
          sfraddr_w_n = ADDR_TXDATA;
          spidata_n   = bus.tx_data;
          state_n     = LOAD;
        end else begin
          tx_ready_n = 1'b1;
        end
      end
      LOAD: begin
        sfraddr_r_n = ADDR_STATUS;
        settle_n    = SETTLE;
        tcnt_n      = '0;
        state_n     = WAIT_LO;
      end
      WAIT_LO: begin
        tcnt_n = tcnt_inc;
        if (timeout_hit) begin
          err_n   = 1'b1;
          spssn_n = 8'hFF;
          state_n = IDLE;
        end else if (settle_q != 2'd0) begin
          settle_n = settle_q - 2'd1;
        end else if (!bus.sfr_data[0]) begin
          // done flag seen low: any stale flag from the previous byte is gone
          state_n = WAIT_HI;
        end
      end
      WAIT_HI: begin
        tcnt_n = tcnt_inc;
        if (timeout_hit) begin
          err_n   = 1'b1;
          spssn_n = 8'hFF;
          state_n = IDLE;
        end else if (bus.sfr_data[0]) begin
          sfraddr_r_n = ADDR_RXDATA;
          settle_n    = SETTLE;
          state_n     = RD;
        end
      end
      RD: begin
        if (settle_q != 2'd0) begin
          settle_n = settle_q - 2'd1;
        end else begin
          rx_data_n  = bus.sfr_data;
          rx_valid_n = 1'b1;
          state_n    = OUT;
        end
      end
      OUT: begin
        if (bus.rx_ready) begin
          rx_valid_n = 1'b0;
          spssn_n    = 8'hFF;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n = CFG1;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.spssn       = spssn_q;
  assign bus.sfraddr_w   = sfraddr_w_q;
  assign bus.sfrwe       = sfrwe_q;
  assign bus.spidata     = spidata_q;
  assign bus.sfraddr_r   = sfraddr_r_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;

endmodule
